mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 25 ++
 rtl/mdu_lat_counter.sv | 35 +++
 rtl/mdu_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, FSM state encoding and latency constants for the MDU control slice.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_MUL = 2'd1,
    ST_BUSY_DIV = 2'd2
  } state_e;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MUL_LAT = 4'd5;
  localparam logic [CNT_W-1:0] DIV_LAT = 4'd10;

endpackage

// File: rtl/mdu_lat_counter.sv
// Busy-cycle counter: loads a latency, counts down to zero, flags the final busy cycle.
module mdu_lat_counter
  import mdu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// MDU issue/stall controller with architectural HI/LO.
// Optional MDU_DIV0_GUARD_EN: divide by zero retires in one cycle without launching the datapath.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] dp_hi,
  input  logic [31:0] dp_lo,
  output logic        stall,
  output logic        busy,
  output logic [3:0]  busy_cnt,
  output logic        dp_start,
  output logic [1:0]  dp_op,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  state_e            state_d, state_q;
  logic [1:0]        dp_op_d, dp_op_q;
  logic [31:0]       dp_a_d, dp_a_q;
  logic [31:0]       dp_b_d, dp_b_q;
  logic [31:0]       hi_d, hi_q;
  logic [31:0]       lo_d, lo_q;
  logic              issue;
  logic              div_zero;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_done;

`ifdef MDU_DIV0_GUARD_EN
  assign div_zero = (rt_val == 32'h0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    dp_op_d      = dp_op_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    issue        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MULT, OP_MULTU: begin
              issue        = 1'b1;
              state_d      = ST_BUSY_MUL;
              cnt_load     = 1'b1;
              cnt_load_val = MUL_LAT;
            end
            OP_DIV, OP_DIVU: begin
              // A guarded divide by zero is simply retired here with no side effects.
              if (!div_zero) begin
                issue        = 1'b1;
                state_d      = ST_BUSY_DIV;
                cnt_load     = 1'b1;
                cnt_load_val = DIV_LAT;
              end
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
          if (issue) begin
            dp_op_d = op_code[1:0];
            dp_a_d  = rs_val;
            dp_b_d  = rt_val;
          end
        end
      end
      ST_BUSY_MUL, ST_BUSY_DIV: begin
        if (cnt_done) begin
          hi_d    = dp_hi;
          lo_d    = dp_lo;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dp_op_q <= '0;
      dp_a_q  <= '0;
      dp_b_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      dp_op_q <= dp_op_d;
      dp_a_q  <= dp_a_d;
      dp_b_q  <= dp_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mdu_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .cnt      (cnt),
    .done     (cnt_done)
  );

  always_comb begin
    rd_data = 32'h0;
    if (op_code == OP_MFHI) begin
      rd_data = hi_q;
    end else if (op_code == OP_MFLO) begin
      rd_data = lo_q;
    end
  end

  // dp_start is gated by reset so no launch can escape while reset is held.
  assign dp_start = issue & reset;
  assign busy     = (state_q != ST_IDLE);
  assign stall    = op_valid & busy;
  assign busy_cnt = cnt;
  assign dp_op    = dp_op_q;
  assign dp_a     = dp_a_q;
  assign dp_b     = dp_b_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
